// File: rtl/sram_arb_pkg.sv
// Shared types and sizes for the SRAM arbiter between VGA scan-out and two Wishbone ports.
package sram_arb_pkg;

   localparam int SRAM_ADR_W = 19;
   localparam int DAT_W      = 8;

   // One SRAM access per cycle; this is the type of the access owning the current cycle.
   typedef enum logic [2:0] {
      SLOT_IDLE = 3'd0,
      SLOT_VGA  = 3'd1,
      SLOT_A_RD = 3'd2,
      SLOT_A_WR = 3'd3,
      SLOT_B_RD = 3'd4,
      SLOT_B_WR = 3'd5
   } slot_t;

   // Round-robin pointer between the two Wishbone ports.
   typedef enum logic {
      RR_A = 1'b0,
      RR_B = 1'b1
   } rr_t;

endpackage

// File: rtl/wb8_port_if.sv
// One Wishbone B4 classic 8-bit port: eligibility, ACK / read-data registers and a saturating wait counter.
//
// Handshake: the master raises I_stb and holds it (with address, WE and write data) until O_ack. O_ack is a
// single-cycle pulse in the cycle after the port's slot; read data is valid in O_dat while O_ack is high.
// I_stb still high during the ACK cycle does not start a new access; the next access can only be granted
// from the cycle after the ACK.
module wb8_port_if
   import sram_arb_pkg::*;
#(
   parameter int WAIT_CNT_W = 16
) (
   input  logic                  I_clk,
   input  logic                  I_reset_n,
   input  logic                  I_stb,
   input  logic                  I_in_slot,
   input  logic                  I_rd_slot,
   input  logic [DAT_W-1:0]      I_sram_dat,
   output logic                  O_eligible,
   output logic                  O_ack,
   output logic [DAT_W-1:0]      O_dat,
   output logic [WAIT_CNT_W-1:0] O_wait
);

   // A port may be granted only when it is strobing, not acknowledging and not already in the slot.
   always_comb begin
      O_eligible = I_stb && !O_ack && !I_in_slot;
   end

   // ACK follows the port's slot by one cycle; read data is latched at the end of the read slot.
   always_ff @(posedge I_clk) begin
      if (!I_reset_n) begin
         O_ack  <= 1'b0;
         O_dat  <= '0;
         O_wait <= '0;
      end else begin
         O_ack <= I_in_slot;
         if (I_rd_slot) begin
            O_dat <= I_sram_dat;
         end
         // A strobing port without a slot and not acking is waiting; the counter sticks at all-ones.
         if (O_eligible && (O_wait != '1)) begin
            O_wait <= O_wait + WAIT_CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/sram_arbiter_wb8.sv
// Single async 8-bit SRAM shared by the VGA fetcher (absolute priority) and two round-robin Wishbone ports.
module sram_arbiter_wb8
   import sram_arb_pkg::*;
#(
   parameter int ADR_W      = SRAM_ADR_W,
   parameter int WAIT_CNT_W = 16
) (
   input  logic                  CLK_I,
   input  logic                  I_reset_n,
   input  logic [ADR_W-1:0]      ADRA_I,
   input  logic [ADR_W-1:0]      ADRB_I,
   input  logic [DAT_W-1:0]      DATA_I,
   input  logic [DAT_W-1:0]      DATB_I,
   input  logic                  STBA_I,
   input  logic                  STBB_I,
   input  logic                  WEA_I,
   input  logic                  WEB_I,
   output logic                  ACKA_O,
   output logic                  ACKB_O,
   output logic [DAT_W-1:0]      DATA_O,
   output logic [DAT_W-1:0]      DATB_O,
   input  logic                  I_vga_req,
   input  logic [ADR_W-1:0]      I_vga_adr,
   output logic [DAT_W-1:0]      O_vga_dat,
   output logic [ADR_W-1:0]      O_sram_adr,
   output logic [DAT_W-1:0]      O_sram_dat,
   output logic                  O_sram_dat_oe,
   input  logic [DAT_W-1:0]      I_sram_dat,
   output logic                  O_sram_we_n,
   output logic                  O_sram_oe_n,
   output logic                  O_sram_ce_n,
   output logic [WAIT_CNT_W-1:0] O_wait_a,
   output logic [WAIT_CNT_W-1:0] O_wait_b,
   output slot_t                 O_dbg_slot
);

   slot_t              slot_q, slot_d;
   rr_t                rr_q, rr_d;
   logic               elig_a, elig_b;
   logic               a_in_slot, b_in_slot;
   logic [ADR_W-1:0]   adr_d;
   logic [DAT_W-1:0]   dat_d;
   logic               dat_oe_d, we_n_d, oe_n_d, ce_n_d;

   // Which port owns the current slot; drives ACK generation and read capture in the port blocks.
   always_comb begin
      a_in_slot  = (slot_q == SLOT_A_RD) || (slot_q == SLOT_A_WR);
      b_in_slot  = (slot_q == SLOT_B_RD) || (slot_q == SLOT_B_WR);
      O_dbg_slot = slot_q;
   end

   wb8_port_if #(.WAIT_CNT_W(WAIT_CNT_W)) u_port_a (
      .I_clk      (CLK_I),
      .I_reset_n  (I_reset_n),
      .I_stb      (STBA_I),
      .I_in_slot  (a_in_slot),
      .I_rd_slot  (slot_q == SLOT_A_RD),
      .I_sram_dat (I_sram_dat),
      .O_eligible (elig_a),
      .O_ack      (ACKA_O),
      .O_dat      (DATA_O),
      .O_wait     (O_wait_a)
   );

   wb8_port_if #(.WAIT_CNT_W(WAIT_CNT_W)) u_port_b (
      .I_clk      (CLK_I),
      .I_reset_n  (I_reset_n),
      .I_stb      (STBB_I),
      .I_in_slot  (b_in_slot),
      .I_rd_slot  (slot_q == SLOT_B_RD),
      .I_sram_dat (I_sram_dat),
      .O_eligible (elig_b),
      .O_ack      (ACKB_O),
      .O_dat      (DATB_O),
      .O_wait     (O_wait_b)
   );

   // Next slot selection (VGA first, then round-robin A/B) and decode of the pad values for that slot.
   always_comb begin
      slot_d   = SLOT_IDLE;
      rr_d     = rr_q;
      adr_d    = O_sram_adr;
      dat_d    = O_sram_dat;
      dat_oe_d = 1'b0;
      we_n_d   = 1'b1;
      oe_n_d   = 1'b1;
      ce_n_d   = 1'b1;

      if (I_vga_req) begin
         slot_d = SLOT_VGA;
      end else if (elig_a && (!elig_b || (rr_q == RR_A))) begin
         slot_d = WEA_I ? SLOT_A_WR : SLOT_A_RD;
         rr_d   = RR_B;
      end else if (elig_b) begin
         slot_d = WEB_I ? SLOT_B_WR : SLOT_B_RD;
         rr_d   = RR_A;
      end

      case (slot_d)
         SLOT_VGA: begin
            adr_d  = I_vga_adr;
            oe_n_d = 1'b0;
            ce_n_d = 1'b0;
         end
         SLOT_A_RD: begin
            adr_d  = ADRA_I;
            oe_n_d = 1'b0;
            ce_n_d = 1'b0;
         end
         SLOT_A_WR: begin
            adr_d    = ADRA_I;
            dat_d    = DATA_I;
            dat_oe_d = 1'b1;
            we_n_d   = 1'b0;
            ce_n_d   = 1'b0;
         end
         SLOT_B_RD: begin
            adr_d  = ADRB_I;
            oe_n_d = 1'b0;
            ce_n_d = 1'b0;
         end
         SLOT_B_WR: begin
            adr_d    = ADRB_I;
            dat_d    = DATB_I;
            dat_oe_d = 1'b1;
            we_n_d   = 1'b0;
            ce_n_d   = 1'b0;
         end
         default: begin
         end
      endcase
   end

   // Slot state, round-robin pointer, SRAM pad registers and the VGA read-data capture.
   always_ff @(posedge CLK_I) begin
      if (!I_reset_n) begin
         slot_q        <= SLOT_IDLE;
         rr_q          <= RR_A;
         O_sram_adr    <= '0;
         O_sram_dat    <= '0;
         O_sram_dat_oe <= 1'b0;
         O_sram_we_n   <= 1'b1;
         O_sram_oe_n   <= 1'b1;
         O_sram_ce_n   <= 1'b1;
         O_vga_dat     <= '0;
      end else begin
         slot_q        <= slot_d;
         rr_q          <= rr_d;
         O_sram_adr    <= adr_d;
         O_sram_dat    <= dat_d;
         O_sram_dat_oe <= dat_oe_d;
         O_sram_we_n   <= we_n_d;
         O_sram_oe_n   <= oe_n_d;
         O_sram_ce_n   <= ce_n_d;
         if (slot_q == SLOT_VGA) begin
            O_vga_dat <= I_sram_dat;
         end
      end
   end

endmodule
